// File: rtl/shared_resource_pipelined_if.sv
// Request/response bus of the pipelined shared resource.
//   master : requester/consumer side (drives in_address, in_id, in_valid, in_resp_rdy)
//   slave  : resource side (drives out_ready, out_data, out_id, out_valid, out_busy, out_count)
// Width macros ADDRESS_WIDTH / DATA_WIDTH / ID_WIDTH fall back to defaults when undefined.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

interface shared_resource_pipelined_if #(
  parameter int unsigned ADDR_W = `ADDRESS_WIDTH,
  parameter int unsigned DATA_W = `DATA_WIDTH,
  parameter int unsigned ID_W   = `ID_WIDTH,
  parameter int unsigned CNT_W  = 3
);
  logic [ADDR_W-1:0] in_address;
  logic [ID_W-1:0]   in_id;
  logic              in_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic              out_valid;
  logic              in_resp_rdy;
  logic              out_busy;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_address, in_id, in_valid, in_resp_rdy,
    input  out_ready, out_data, out_id, out_valid, out_busy, out_count
  );

  modport slave (
    input  in_address, in_id, in_valid, in_resp_rdy,
    output out_ready, out_data, out_id, out_valid, out_busy, out_count
  );
endinterface

// File: rtl/shared_resource_pipelined.sv
// Pipelined shared resource model: accepts tagged address requests into an in-order
// circular FIFO of DEPTH entries and returns {address + OFFSET, id} once the entry has
// aged DELAY cycles. The response side is valid/ready so a slow consumer back-pressures.
// Ports:
//   clk, reset  clock; asynchronous active-high reset
//   in_flush    flush all in-flight entries (only when SHARED_RES_FLUSH_EN is defined)
//   bus         shared_resource_pipelined_if.slave request/response bus
// All bus outputs are decoded from registered state only (no in->out path).
// Optional feature macro: SHARED_RES_FLUSH_EN.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef RESOURCE_DELAY
`define RESOURCE_DELAY 4
`endif

module shared_resource_pipelined #(
  parameter int unsigned ADDR_W = `ADDRESS_WIDTH,
  parameter int unsigned DATA_W = `DATA_WIDTH,
  parameter int unsigned ID_W   = `ID_WIDTH,
  parameter int unsigned DELAY  = `RESOURCE_DELAY,
  parameter int unsigned DEPTH  = 4,
  parameter logic [31:0] OFFSET = 32'h200,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
`ifdef SHARED_RES_FLUSH_EN
  input  logic in_flush,
`endif
  shared_resource_pipelined_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TMR_W = $clog2(DELAY + 1);

  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [ID_W-1:0]   id_q    [DEPTH];
  logic [ID_W-1:0]   id_d    [DEPTH];
  logic [TMR_W-1:0]  timer_q [DEPTH];
  logic [TMR_W-1:0]  timer_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic head_valid;
  logic head_done;
  logic not_full;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = valid_q[rd_ptr_q];
  assign head_done  = (timer_q[rd_ptr_q] == TMR_W'(DELAY));
  assign not_full   = (count_q < CNT_W'(DEPTH));

  assign bus.out_ready = not_full;
  assign bus.out_valid = head_valid & head_done;
  assign bus.out_data  = head_valid ? data_q[rd_ptr_q] : '0;
  assign bus.out_id    = head_valid ? id_q[rd_ptr_q]   : '0;
  assign bus.out_busy  = (count_q != '0);
  assign bus.out_count = count_q;

  assign push = bus.in_valid & not_full;
  assign pop  = bus.out_valid & bus.in_resp_rdy;

  always_comb begin
    data_d   = data_q;
    id_d     = id_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Every valid entry ages each cycle, independent of head stalls.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (timer_q[i] != TMR_W'(DELAY))) begin
        timer_d[i] = timer_q[i] + 1'b1;
      end
    end

    // Push never targets the popped slot: a push needs count < DEPTH, so wr != rd
    // whenever a pop is possible.
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end

    if (push) begin
      data_d[wr_ptr_q]  = DATA_W'(bus.in_address) + DATA_W'(OFFSET);
      id_d[wr_ptr_q]    = bus.in_id;
      timer_d[wr_ptr_q] = TMR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

`ifdef SHARED_RES_FLUSH_EN
    // Flush overrides any same-cycle push or pop.
    if (in_flush) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        id_q[i]    <= '0;
        timer_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      id_q     <= id_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_shared_resource_pipelined.sv
// Directed bench for shared_resource_pipelined: two instances, one wide-data DELAY=4/DEPTH=4
// and one with DATA_W=ADDR_W for address wrap.
module tb_shared_resource_pipelined;

  logic clk = 1'b0;
  logic reset;
`ifdef SHARED_RES_FLUSH_EN
  logic flush0 = 1'b0;
  logic flush1 = 1'b0;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  shared_resource_pipelined_if #(.ADDR_W(8), .DATA_W(16), .ID_W(4), .CNT_W(3)) bus0 ();
  shared_resource_pipelined_if #(.ADDR_W(10), .DATA_W(10), .ID_W(4), .CNT_W(2)) bus1 ();

  shared_resource_pipelined #(
    .ADDR_W(8), .DATA_W(16), .ID_W(4), .DELAY(4), .DEPTH(4), .OFFSET(32'h200), .CNT_W(3)
  ) dut0 (
    .clk(clk),
    .reset(reset),
`ifdef SHARED_RES_FLUSH_EN
    .in_flush(flush0),
`endif
    .bus(bus0.slave)
  );

  shared_resource_pipelined #(
    .ADDR_W(10), .DATA_W(10), .ID_W(4), .DELAY(2), .DEPTH(2), .OFFSET(32'h200), .CNT_W(2)
  ) dut1 (
    .clk(clk),
    .reset(reset),
`ifdef SHARED_RES_FLUSH_EN
    .in_flush(flush1),
`endif
    .bus(bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock and settle 1ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] addr, input logic [3:0] id);
    bus0.in_valid   = 1'b1;
    bus0.in_address = addr;
    bus0.in_id      = id;
    step();
    bus0.in_valid   = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus0.in_valid    = 1'b0;
    bus0.in_address  = '0;
    bus0.in_id       = '0;
    bus0.in_resp_rdy = 1'b0;
    bus1.in_valid    = 1'b0;
    bus1.in_address  = '0;
    bus1.in_id       = '0;
    bus1.in_resp_rdy = 1'b0;
    #22;
    reset = 1'b0;
    step();

    // Reset state
    check("rst_count", 32'(bus0.out_count), 32'd0);
    check("rst_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_ready", 32'(bus0.out_ready), 32'd1);
    check("rst_busy",  32'(bus0.out_busy),  32'd0);
    check("rst_data",  32'(bus0.out_data),  32'd0);
    check("rst_id",    32'(bus0.out_id),    32'd0);

    // 1: single request, latency DELAY, one-cycle response
    bus0.in_resp_rdy = 1'b1;
    push0(8'h05, 4'd2);
    check("t1_busy", 32'(bus0.out_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("t1_early_valid", 32'(bus0.out_valid), 32'd0);
      if (i < 2) step();
    end
    step();
    check("t1_valid", 32'(bus0.out_valid), 32'd1);
    check("t1_data",  32'(bus0.out_data),  32'h205);
    check("t1_id",    32'(bus0.out_id),    32'd2);
    step();
    check("t1_popped_valid", 32'(bus0.out_valid), 32'd0);
    check("t1_popped_count", 32'(bus0.out_count), 32'd0);

    // 2: fill to DEPTH, extra request ignored, in-order drain
    bus0.in_resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push0(8'(8'h10 + i), 4'(i));
    check("t2_count_full", 32'(bus0.out_count), 32'd4);
    check("t2_ready_full", 32'(bus0.out_ready), 32'd0);
    bus0.in_valid   = 1'b1;
    bus0.in_address = 8'h99;
    bus0.in_id      = 4'd9;
    for (int i = 0; i < 5; i++) step();
    bus0.in_valid = 1'b0;
    check("t2_count_hold", 32'(bus0.out_count), 32'd4);
    bus0.in_resp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", 32'(bus0.out_valid), 32'd1);
      check("t2_drain_id",    32'(bus0.out_id),    32'(i));
      check("t2_drain_data",  32'(bus0.out_data),  32'(16'h210 + i));
      step();
    end
    check("t2_empty_valid", 32'(bus0.out_valid), 32'd0);
    check("t2_empty_count", 32'(bus0.out_count), 32'd0);

    // 3: head stalled 10 cycles, then one pop per cycle
    bus0.in_resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push0(8'(8'h20 + i), 4'(5 + i));
    for (int i = 0; i < 10; i++) step();
    check("t3_stall_valid", 32'(bus0.out_valid), 32'd1);
    check("t3_stall_id",    32'(bus0.out_id),    32'd5);
    bus0.in_resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t3_valid", 32'(bus0.out_valid), 32'd1);
      check("t3_id",    32'(bus0.out_id),    32'(5 + i));
      step();
    end
    check("t3_empty", 32'(bus0.out_count), 32'd0);

    // 4: simultaneous push and pop at count=2
    bus0.in_resp_rdy = 1'b0;
    push0(8'h30, 4'd1);
    push0(8'h31, 4'd2);
    for (int i = 0; i < 4; i++) step();
    check("t4_count2", 32'(bus0.out_count), 32'd2);
    bus0.in_valid    = 1'b1;
    bus0.in_address  = 8'h32;
    bus0.in_id       = 4'd3;
    bus0.in_resp_rdy = 1'b1;
    check("t4_head_id", 32'(bus0.out_id), 32'd1);
    step();
    bus0.in_valid    = 1'b0;
    bus0.in_resp_rdy = 1'b0;
    check("t4_count_same", 32'(bus0.out_count), 32'd2);
    check("t4_b_id",   32'(bus0.out_id),   32'd2);
    check("t4_b_data", 32'(bus0.out_data), 32'h231);
    for (int i = 0; i < 3; i++) step();
    bus0.in_resp_rdy = 1'b1;
    check("t4_b_valid", 32'(bus0.out_valid), 32'd1);
    step();
    check("t4_c_valid", 32'(bus0.out_valid), 32'd1);
    check("t4_c_id",    32'(bus0.out_id),    32'd3);
    check("t4_c_data",  32'(bus0.out_data),  32'h232);
    step();
    check("t4_empty", 32'(bus0.out_count), 32'd0);

    // 5: all-ones address with DATA_W=ADDR_W wraps
    bus1.in_resp_rdy = 1'b1;
    bus1.in_valid    = 1'b1;
    bus1.in_address  = 10'h3FF;
    bus1.in_id       = 4'd1;
    step();
    bus1.in_valid = 1'b0;
    check("t5_early_valid", 32'(bus1.out_valid), 32'd0);
    step();
    check("t5_valid", 32'(bus1.out_valid), 32'd1);
    check("t5_data",  32'(bus1.out_data),  32'h1FF);
    check("t5_id",    32'(bus1.out_id),    32'd1);
    step();
    check("t5_empty", 32'(bus1.out_count), 32'd0);

`ifdef SHARED_RES_FLUSH_EN
    // 6: flush with 3 in flight and a concurrent request
    bus0.in_resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) push0(8'(8'h40 + i), 4'(i));
    flush0          = 1'b1;
    bus0.in_valid   = 1'b1;
    bus0.in_address = 8'h50;
    bus0.in_id      = 4'd7;
    step();
    flush0        = 1'b0;
    bus0.in_valid = 1'b0;
    check("t6_count", 32'(bus0.out_count), 32'd0);
    check("t6_valid", 32'(bus0.out_valid), 32'd0);
    check("t6_ready", 32'(bus0.out_ready), 32'd1);
    bus0.in_resp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t6_no_stale", 32'(bus0.out_valid), 32'd0);
      step();
    end
`endif

    // Asynchronous reset mid-operation
    bus0.in_resp_rdy = 1'b0;
    push0(8'h60, 4'd4);
    push0(8'h61, 4'd5);
    for (int i = 0; i < 5; i++) step();
    check("ar_pre_valid", 32'(bus0.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", 32'(bus0.out_count), 32'd0);
    check("ar_valid", 32'(bus0.out_valid), 32'd0);
    check("ar_ready", 32'(bus0.out_ready), 32'd1);
    check("ar_busy",  32'(bus0.out_busy),  32'd0);
    check("ar_data",  32'(bus0.out_data),  32'd0);
    check("ar_id",    32'(bus0.out_id),    32'd0);
    step();
    reset = 1'b0;
    step();
    check("ar_after_count", 32'(bus0.out_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
